// File: rtl/lab2_proc_mem_responder.sv
// Memory responder for processor imem/dmem val/rdy streams.
// Word array access at accept, fixed-latency pipe, in-order out FIFO.
module lab2_proc_mem_responder #(
  parameter int p_addr_nbits = 8,
  parameter int p_latency    = 1,
  parameter int p_max_outstd = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reqstream_val,
  output logic        reqstream_rdy,
  input  logic [76:0] reqstream_msg,
  output logic        respstream_val,
  input  logic        respstream_rdy,
  output logic [46:0] respstream_msg
);

  localparam int CW = $clog2(p_max_outstd + 1);
  localparam int PW = (p_max_outstd > 1) ? $clog2(p_max_outstd) : 1;
  localparam logic [PW-1:0] LASTP = PW'(p_max_outstd - 1);

  logic [2:0]              w_type;
  logic [7:0]              w_opq;
  logic [31:0]             w_addr;
  logic [1:0]              w_len;
  logic [31:0]             w_data;
  logic [p_addr_nbits-1:0] w_idx;
  logic [1:0]              w_lane;
  logic                    w_unused;

  assign w_type   = reqstream_msg[76:74];
  assign w_opq    = reqstream_msg[73:66];
  assign w_addr   = reqstream_msg[65:34];
  assign w_len    = reqstream_msg[33:32];
  assign w_data   = reqstream_msg[31:0];
  assign w_idx    = w_addr[p_addr_nbits+1:2];
  assign w_lane   = w_addr[1:0];
  assign w_unused = ^w_addr[31:p_addr_nbits+2];

  logic [31:0] r_mem [2**p_addr_nbits];
  logic [31:0] w_word;
  logic [3:0]  w_bmask;
  logic [3:0]  w_wmask;
  logic [31:0] w_rmask;
  logic [31:0] w_rdata;
  logic [31:0] w_wword;
  logic        w_rd;
  logic        w_wr;
  logic        w_acc;
  logic        w_pop;
  logic        w_push;
  logic [46:0] w_resp;

  logic [CW-1:0] r_outstd;
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic          r_pv [p_latency];
  logic [46:0]   r_pm [p_latency];
  logic [46:0]   r_fifo [p_max_outstd];

  assign w_word = r_mem[w_idx];
  assign w_rd   = (w_type == 3'd0);
  assign w_wr   = (w_type == 3'd1) || (w_type == 3'd2);

  // Byte lanes touched: len bytes starting at lane, clipped at lane 3
  always_comb begin
    w_bmask = 4'hf;
    unique case (w_len)
      2'd1:    w_bmask = 4'h1;
      2'd2:    w_bmask = 4'h3;
      2'd3:    w_bmask = 4'h7;
      default: w_bmask = 4'hf;
    endcase
  end

  assign w_rmask = {{8{w_bmask[3]}}, {8{w_bmask[2]}},
                    {8{w_bmask[1]}}, {8{w_bmask[0]}}};
  assign w_rdata = (w_word >> {w_lane, 3'b000}) & w_rmask;
  assign w_wmask = w_bmask << w_lane;
  assign w_wword = w_data << {w_lane, 3'b000};

  assign reqstream_rdy = reset && (r_outstd < CW'(p_max_outstd));
  assign w_acc  = reqstream_val && reqstream_rdy;
  assign w_pop  = respstream_val && respstream_rdy;
  assign w_push = r_pv[p_latency-1];
  assign w_resp = {w_type, w_opq, 2'b00, w_len,
                   w_rd ? w_rdata : 32'd0};

  // Array write at the accept edge; contents survive reset
  always_ff @(posedge clk) begin
    if (w_acc && w_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (w_wmask[b]) r_mem[w_idx][8*b +: 8] <= w_wword[8*b +: 8];
      end
    end
  end

  // Fixed-latency response shift pipe, never stalls
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < p_latency; s++) begin
        r_pv[s] <= 1'b0;
        r_pm[s] <= '0;
      end
    end else begin
      r_pv[0] <= w_acc;
      r_pm[0] <= w_resp;
      for (int s = 1; s < p_latency; s++) begin
        r_pv[s] <= r_pv[s-1];
        r_pm[s] <= r_pm[s-1];
      end
    end
  end

  // Output FIFO storage
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wp] <= r_pm[p_latency-1];
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= (r_wp == LASTP) ? '0 : r_wp + 1'b1;
      if (w_pop)  r_rp <= (r_rp == LASTP) ? '0 : r_rp + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Outstanding requests: pipe plus FIFO
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_outstd <= '0;
    end else begin
      unique case ({w_acc, w_pop})
        2'b10:   r_outstd <= r_outstd + 1'b1;
        2'b01:   r_outstd <= r_outstd - 1'b1;
        default: r_outstd <= r_outstd;
      endcase
    end
  end

  assign respstream_val = (r_cnt != '0);
  assign respstream_msg = respstream_val ? r_fifo[r_rp] : '0;

endmodule

// File: tb/tb_lab2_proc_mem_responder.sv
// Bench for lab2_proc_mem_responder.
// Byte-level memory model and response queue as reference.
module tb_lab2_proc_mem_responder;

  localparam int LAT = 1;
  localparam int MAXO = 4;
  localparam logic [2:0] T_RD = 3'd0;
  localparam logic [2:0] T_WR = 3'd1;
  localparam logic [2:0] T_IN = 3'd2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        reqstream_val = 1'b0;
  logic        reqstream_rdy;
  logic [76:0] reqstream_msg = '0;
  logic        respstream_val;
  logic        respstream_rdy = 1'b0;
  logic [46:0] respstream_msg;

  int checks = 0;
  int failures = 0;

  logic [31:0] m_mem [256];
  logic [46:0] expq [$];
  logic        s_rdy;
  logic        s_val;
  logic [46:0] s_msg;

  lab2_proc_mem_responder #(
    .p_addr_nbits(8),
    .p_latency(LAT),
    .p_max_outstd(MAXO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .reqstream_val(reqstream_val),
    .reqstream_rdy(reqstream_rdy),
    .reqstream_msg(reqstream_msg),
    .respstream_val(respstream_val),
    .respstream_rdy(respstream_rdy),
    .respstream_msg(respstream_msg)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [76:0] req(input logic [2:0] t,
      input logic [7:0] o, input logic [31:0] a,
      input logic [1:0] l, input logic [31:0] d);
    return {t, o, a, l, d};
  endfunction

  // Reference: bytes as mask/shift arithmetic on a 64-bit scratch
  function automatic logic [46:0] model(input logic [76:0] q);
    logic [2:0]  t;
    logic [7:0]  idx;
    int          lane;
    int          n;
    logic [63:0] mask;
    logic [63:0] mw;
    logic [63:0] dw;
    logic [31:0] rd;
    t    = q[76:74];
    idx  = q[43:36];
    lane = int'(q[35:34]);
    n    = (q[33:32] == 2'd0) ? 4 : int'(q[33:32]);
    mask = (64'd1 << (8 * n)) - 64'd1;
    rd   = 32'((64'(m_mem[idx]) >> (8 * lane)) & mask);
    if (t == T_WR || t == T_IN) begin
      mw = (mask << (8 * lane)) & 64'hffff_ffff;
      dw = (64'(q[31:0]) << (8 * lane)) & mw;
      m_mem[idx] = 32'((64'(m_mem[idx]) & ~mw) | dw);
    end
    return {t, q[73:66], 2'b00, q[33:32], (t == T_RD) ? rd : 32'd0};
  endfunction

  task automatic drive(input bit v, input logic [76:0] m,
      input bit rr, output bit acc, output bit pop,
      output logic [46:0] pexp);
    @(negedge clk);
    s_rdy = reqstream_rdy;
    s_val = respstream_val;
    s_msg = respstream_msg;
    reqstream_val  = v;
    reqstream_msg  = m;
    respstream_rdy = rr;
    acc  = v && s_rdy;
    pop  = s_val && rr;
    pexp = 'x;
    if (pop && expq.size() > 0) pexp = expq.pop_front();
    if (acc) expq.push_back(model(m));
  endtask

  task automatic test_reset();
    bit acc, pop;
    logic [46:0] pe;
    reset = 1'b0;
    repeat (2) drive(0, '0, 0, acc, pop, pe);
    checks++;
    if (s_rdy !== 1'b0) begin
      failures++;
      $display("FAIL rst_rdy got=%b exp=0", s_rdy);
    end
    checks++;
    if (s_val !== 1'b0) begin
      failures++;
      $display("FAIL rst_val got=%b exp=0", s_val);
    end
    checks++;
    if (s_msg !== 47'd0) begin
      failures++;
      $display("FAIL rst_msg got=%h exp=0", s_msg);
    end
    reset = 1'b1;
    drive(0, '0, 0, acc, pop, pe);
    checks++;
    if (s_rdy !== 1'b1) begin
      failures++;
      $display("FAIL rel_rdy got=%b exp=1", s_rdy);
    end
    for (int c = 0; c < 3; c++) begin
      drive(0, '0, 1, acc, pop, pe);
      checks++;
      if (s_val !== 1'b0) begin
        failures++;
        $display("FAIL idle_val c=%0d got=%b exp=0", c, s_val);
      end
    end
  endtask

  task automatic test_init_read();
    bit acc, pop;
    logic [46:0] pe;
    logic [46:0] rd;
    int n;
    n = 0;
    rd = '0;
    drive(1, req(T_IN, 8'h5a, 32'h10, 2'd0, 32'hdeadbeef), 1, acc, pop, pe);
    checks++;
    if (!acc) begin
      failures++;
      $display("FAIL init_acc got=0 exp=1");
    end
    drive(1, req(T_RD, 8'h3c, 32'h10, 2'd0, 32'h0), 1, acc, pop, pe);
    for (int c = 1; c <= 20 && expq.size() > 0; c++) begin
      drive(0, '0, 1, acc, pop, pe);
      if (pop) begin
        checks++;
        if (s_msg !== pe) begin
          failures++;
          $display("FAIL ir_resp got=%h exp=%h", s_msg, pe);
        end
        if (s_msg[46:44] == T_RD) begin
          n = c;
          rd = s_msg;
        end
      end
    end
    checks++;
    if (n != LAT + 1) begin
      failures++;
      $display("FAIL ir_latency got=%0d exp=%0d", n, LAT + 1);
    end
    checks++;
    if (rd[31:0] !== 32'hdeadbeef) begin
      failures++;
      $display("FAIL ir_data got=%h exp=deadbeef", rd[31:0]);
    end
    checks++;
    if (rd[43:36] !== 8'h3c) begin
      failures++;
      $display("FAIL ir_opaque got=%h exp=3c", rd[43:36]);
    end
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL ir_drain left=%0d exp=0", expq.size());
    end
  endtask

  task automatic test_subword();
    bit acc, pop;
    logic [46:0] pe;
    logic [31:0] got [4];
    int k;
    k = 0;
    for (int i = 0; i < 4; i++) got[i] = '0;
    drive(1, req(T_IN, 8'h01, 32'h20, 2'd0, 32'h11223344), 1, acc, pop, pe);
    drive(1, req(T_WR, 8'h02, 32'h21, 2'd1, 32'h000000ab), 1, acc, pop, pe);
    if (pop) begin
      got[k] = s_msg[31:0];
      k++;
    end
    drive(1, req(T_RD, 8'h03, 32'h20, 2'd0, 32'h0), 1, acc, pop, pe);
    if (pop) begin
      got[k] = s_msg[31:0];
      k++;
    end
    drive(1, req(T_RD, 8'h04, 32'h22, 2'd2, 32'h0), 1, acc, pop, pe);
    if (pop) begin
      got[k] = s_msg[31:0];
      k++;
    end
    for (int c = 0; c < 20 && expq.size() > 0; c++) begin
      drive(0, '0, 1, acc, pop, pe);
      if (pop) begin
        checks++;
        if (s_msg !== pe) begin
          failures++;
          $display("FAIL sw_resp got=%h exp=%h", s_msg, pe);
        end
        if (k < 4) begin
          got[k] = s_msg[31:0];
          k++;
        end
      end
    end
    checks++;
    if (got[2] !== 32'h1122ab44) begin
      failures++;
      $display("FAIL sw_word got=%h exp=1122ab44", got[2]);
    end
    checks++;
    if (got[3] !== 32'h00001122) begin
      failures++;
      $display("FAIL sw_half got=%h exp=00001122", got[3]);
    end
  endtask

  task automatic test_backpressure();
    bit acc, pop;
    logic [46:0] pe;
    logic [46:0] held;
    int na;
    int np;
    na = 0;
    np = 0;
    for (int k = 0; k < 6; k++) begin
      drive(1, req(T_RD, 8'(8'h80 + k), 32'h10, 2'd0, 32'h0), 0,
            acc, pop, pe);
      if (acc) na++;
    end
    checks++;
    if (na != MAXO) begin
      failures++;
      $display("FAIL bp_accepts got=%0d exp=%0d", na, MAXO);
    end
    drive(0, '0, 0, acc, pop, pe);
    checks++;
    if (s_rdy !== 1'b0) begin
      failures++;
      $display("FAIL bp_rdy_full got=%b exp=0", s_rdy);
    end
    held = s_msg;
    for (int c = 0; c < 2; c++) begin
      drive(0, '0, 0, acc, pop, pe);
      checks++;
      if (s_val !== 1'b1 || s_msg !== held) begin
        failures++;
        $display("FAIL bp_hold val=%b msg=%h exp=1 %h", s_val, s_msg, held);
      end
    end
    drive(0, '0, 1, acc, pop, pe);
    checks++;
    if (!pop || s_msg !== pe) begin
      failures++;
      $display("FAIL bp_first pop=%b got=%h exp=%h", pop, s_msg, pe);
    end
    if (pop) np++;
    drive(0, '0, 1, acc, pop, pe);
    checks++;
    if (s_rdy !== 1'b1) begin
      failures++;
      $display("FAIL bp_rdy_back got=%b exp=1", s_rdy);
    end
    if (pop) begin
      np++;
      checks++;
      if (s_msg !== pe) begin
        failures++;
        $display("FAIL bp_resp got=%h exp=%h", s_msg, pe);
      end
    end
    for (int c = 0; c < 20 && expq.size() > 0; c++) begin
      drive(0, '0, 1, acc, pop, pe);
      if (pop) begin
        np++;
        checks++;
        if (s_msg !== pe) begin
          failures++;
          $display("FAIL bp_resp got=%h exp=%h", s_msg, pe);
        end
      end
    end
    checks++;
    if (np != MAXO) begin
      failures++;
      $display("FAIL bp_pops got=%0d exp=%0d", np, MAXO);
    end
  endtask

  task automatic test_accept_pop();
    bit acc, pop;
    logic [46:0] pe;
    int na;
    int np;
    logic [2:0] t;
    na = 0;
    np = 0;
    for (int c = 0; c < 10 && na < MAXO; c++) begin
      drive(1, req(T_RD, 8'(8'h40 + na), 32'h10, 2'd0, 32'h0), 0,
            acc, pop, pe);
      if (acc) na++;
    end
    repeat (2) drive(0, '0, 0, acc, pop, pe);
    for (int c = 1; c <= 10; c++) begin
      t = ($urandom_range(0, 1) == 0) ? T_RD : T_WR;
      drive(1, req(t, 8'(8'h50 + c), 32'h10, 2'($urandom_range(0, 3)),
            32'($urandom)), 1, acc, pop, pe);
      if (acc) na++;
      if (c >= 2) begin
        checks++;
        if (s_rdy !== 1'b1) begin
          failures++;
          $display("FAIL ap_rdy c=%0d got=%b exp=1", c, s_rdy);
        end
      end
      if (pop) begin
        np++;
        checks++;
        if (s_msg !== pe) begin
          failures++;
          $display("FAIL ap_resp got=%h exp=%h", s_msg, pe);
        end
      end
    end
    for (int c = 0; c < 30 && expq.size() > 0; c++) begin
      drive(0, '0, 1, acc, pop, pe);
      if (pop) begin
        np++;
        checks++;
        if (s_msg !== pe) begin
          failures++;
          $display("FAIL ap_resp got=%h exp=%h", s_msg, pe);
        end
      end
    end
    checks++;
    if (np != na) begin
      failures++;
      $display("FAIL ap_count pops=%0d exp=%0d", np, na);
    end
  endtask

  task automatic test_reset_mid();
    bit acc, pop;
    logic [46:0] pe;
    logic [31:0] rd;
    rd = '0;
    drive(1, req(T_WR, 8'h11, 32'h30, 2'd0, 32'hcafef00d), 1, acc, pop, pe);
    for (int k = 0; k < 3; k++)
      drive(1, req(T_RD, 8'(8'h20 + k), 32'h30, 2'd0, 32'h0), 0,
            acc, pop, pe);
    repeat (2) drive(0, '0, 0, acc, pop, pe);
    checks++;
    if (s_val !== 1'b1) begin
      failures++;
      $display("FAIL rm_pending got=%b exp=1", s_val);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (respstream_val !== 1'b0 || reqstream_rdy !== 1'b0) begin
      failures++;
      $display("FAIL rm_async val=%b rdy=%b exp=0 0",
               respstream_val, reqstream_rdy);
    end
    expq.delete();
    repeat (2) drive(0, '0, 0, acc, pop, pe);
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      drive(0, '0, 1, acc, pop, pe);
      checks++;
      if (s_val !== 1'b0) begin
        failures++;
        $display("FAIL rm_stale c=%0d got=%b exp=0", c, s_val);
      end
    end
    drive(1, req(T_RD, 8'h77, 32'h30, 2'd0, 32'h0), 1, acc, pop, pe);
    for (int c = 0; c < 20 && expq.size() > 0; c++) begin
      drive(0, '0, 1, acc, pop, pe);
      if (pop) begin
        rd = s_msg[31:0];
        checks++;
        if (s_msg !== pe) begin
          failures++;
          $display("FAIL rm_resp got=%h exp=%h", s_msg, pe);
        end
      end
    end
    checks++;
    if (rd !== 32'hcafef00d) begin
      failures++;
      $display("FAIL rm_keep got=%h exp=cafef00d", rd);
    end
  endtask

  task automatic test_random();
    bit acc, pop;
    logic [46:0] pe;
    logic [76:0] m;
    logic [31:0] a;
    logic [2:0]  t;
    int r;
    for (int i = 0; i < 16; i++) begin
      drive(1, req(T_IN, 8'(i), 32'(32'h40 + 4 * i), 2'd0, 32'($urandom)),
            1, acc, pop, pe);
      if (pop) begin
        checks++;
        if (s_msg !== pe) begin
          failures++;
          $display("FAIL rnd_resp got=%h exp=%h", s_msg, pe);
        end
      end
    end
    for (int c = 0; c < 400; c++) begin
      r = int'($urandom_range(0, 9));
      if (r < 5) t = T_RD;
      else if (r < 7) t = T_WR;
      else if (r == 7) t = T_IN;
      else if (r == 8) t = 3'd3;
      else t = 3'd7;
      a = $urandom;
      a[9:2] = 8'(16 + $urandom_range(0, 15));
      m = req(t, 8'($urandom), a, 2'($urandom_range(0, 3)), 32'($urandom));
      drive(($urandom_range(0, 3) != 0), m, ($urandom_range(0, 9) < 7),
            acc, pop, pe);
      if (pop) begin
        checks++;
        if (s_msg !== pe) begin
          failures++;
          $display("FAIL rnd_resp got=%h exp=%h", s_msg, pe);
        end
      end
    end
    for (int c = 0; c < 60 && expq.size() > 0; c++) begin
      drive(0, '0, 1, acc, pop, pe);
      if (pop) begin
        checks++;
        if (s_msg !== pe) begin
          failures++;
          $display("FAIL rnd_resp got=%h exp=%h", s_msg, pe);
        end
      end
    end
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL rnd_drain left=%0d exp=0", expq.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) m_mem[i] = '0;
    test_reset();
    test_init_read();
    test_subword();
    test_backpressure();
    test_accept_pop();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
